// File: rtl/sr_flag_sched.sv
// Round-robin arbiter for set/clear commands on a bank of SR status flags,
// with a one-flag-per-cycle clear-all sweep and registered s/r drive pulses.
module sr_flag_sched #(
  parameter int N_REQ  = 4,
  parameter int N_FLAG = 8,
  parameter int FW     = $clog2(N_FLAG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_op,
  input  logic [N_REQ*FW-1:0]   req_idx,
  output logic [N_REQ-1:0]      req_gnt,
  input  logic                  clr_all,
  output logic [N_FLAG-1:0]     flags,
  output logic [N_FLAG-1:0]     s_drv,
  output logic [N_FLAG-1:0]     r_drv,
  output logic                  busy,
  output logic                  sweep_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(N_FLAG + 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_FLAG-1:0] flags_q, flags_d;
  logic [N_FLAG-1:0] s_q, s_d;
  logic [N_FLAG-1:0] r_q, r_d;
  logic              done_q, done_d;

  logic              found;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     pos;
  logic [FW-1:0]     tgt;
  logic [N_REQ-1:0]  gnt_v;
  int unsigned       p;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    s_d     = '0;
    r_d     = '0;
    done_d  = 1'b0;
    gnt_v   = '0;
    found   = 1'b0;
    sel     = '0;
    pos     = '0;
    tgt     = '0;
    p       = 0;

    case (state_q)
      IDLE: begin
        if (clr_all) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          for (int unsigned k = 0; k < N_REQ; k++) begin
            p = 32'(ptr_q) + k;
            if (p >= N_REQ) p = p - N_REQ;
            pos = PW'(p);
            if (!found && req_valid[pos]) begin
              found = 1'b1;
              sel   = pos;
            end
          end
          if (found) begin
            gnt_v[sel] = 1'b1;
            ptr_d      = (32'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
            tgt        = req_idx[sel*FW +: FW];
            // Out-of-range indices are accepted but have no effect.
            if (32'(tgt) < N_FLAG) begin
              flags_d[tgt] = req_op[sel];
              if (req_op[sel]) s_d[tgt] = 1'b1;
              else             r_d[tgt] = 1'b1;
            end
          end
        end
      end
      SWEEP: begin
        // Extra cycle at cnt==N_FLAG lets the last pulse retire before done.
        if (cnt_q == CW'(N_FLAG)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          r_d[cnt_q[FW-1:0]]     = 1'b1;
          flags_d[cnt_q[FW-1:0]] = 1'b0;
          cnt_d                  = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    req_gnt = rst ? '0 : gnt_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      s_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign flags      = flags_q;
  assign s_drv      = s_q;
  assign r_drv      = r_q;
  assign sweep_done = done_q;
  assign busy       = (state_q == SWEEP) && (cnt_q != CW'(N_FLAG));

endmodule

// File: tb/tb_sr_flag_sched.sv
// Scoreboard bench for sr_flag_sched: stimulus queues cycle-stamped grant and
// pulse expectations, per-DUT monitors pop and compare on every DUT event.
module tb_sr_flag_sched;

  typedef struct {int cyc; logic [7:0] gnt;} g_t;
  typedef struct {int cyc; logic [7:0] s; logic [7:0] r; logic [7:0] fl; logic bz; logic dn;} p_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst, clr_all;
  logic [3:0]  req_valid, req_op, req_gnt;
  logic [11:0] req_idx;
  logic [7:0]  flags, s_drv, r_drv;
  logic        busy, sweep_done;

  logic [1:0]  req_valid6, req_op6, req_gnt6;
  logic [5:0]  req_idx6;
  logic [5:0]  flags6, s_drv6, r_drv6;
  logic        busy6, sweep_done6;

  sr_flag_sched #(.N_REQ(4), .N_FLAG(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_gnt(req_gnt), .clr_all(clr_all), .flags(flags), .s_drv(s_drv), .r_drv(r_drv),
    .busy(busy), .sweep_done(sweep_done));

  sr_flag_sched #(.N_REQ(2), .N_FLAG(6)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid6), .req_op(req_op6), .req_idx(req_idx6),
    .req_gnt(req_gnt6), .clr_all(1'b0), .flags(flags6), .s_drv(s_drv6), .r_drv(r_drv6),
    .busy(busy6), .sweep_done(sweep_done6));

  int n_cmp = 0;
  int n_bad = 0;
  g_t gq[$], gq6[$];
  p_t pq[$], pq6[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_g(input bit b, input int c, input logic [7:0] g);
    g_t e;
    e.cyc = c; e.gnt = g;
    if (b) gq6.push_back(e); else gq.push_back(e);
  endtask

  task automatic exp_p(input bit b, input int c, input logic [7:0] s, input logic [7:0] r,
                       input logic [7:0] fl, input logic bz, input logic dn);
    p_t e;
    e.cyc = c; e.s = s; e.r = r; e.fl = fl; e.bz = bz; e.dn = dn;
    if (b) pq6.push_back(e); else pq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4x8 instance
  g_t ge; p_t pe;
  always @(negedge clk) begin
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      ge = gq.pop_front();
      chk("gnt_missed", 32'(cyc), 32'(ge.cyc));
    end
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      pe = pq.pop_front();
      chk("pulse_missed", 32'(cyc), 32'(pe.cyc));
    end
    if (req_gnt != '0) begin
      if (gq.size() == 0) chk("gnt_unexpected", 32'(req_gnt), 32'(0));
      else begin
        ge = gq.pop_front();
        chk("gnt_cyc", 32'(cyc), 32'(ge.cyc));
        chk("gnt", 32'(req_gnt), 32'(ge.gnt));
      end
    end
    if ((s_drv | r_drv) != '0 || sweep_done) begin
      chk("s_and_r", 32'(s_drv & r_drv), 32'(0));
      if (pq.size() == 0) chk("pulse_unexpected", 32'({s_drv, r_drv, 7'd0, sweep_done}), 32'(0));
      else begin
        pe = pq.pop_front();
        chk("pulse_cyc", 32'(cyc), 32'(pe.cyc));
        chk("s_drv", 32'(s_drv), 32'(pe.s));
        chk("r_drv", 32'(r_drv), 32'(pe.r));
        chk("flags", 32'(flags), 32'(pe.fl));
        chk("busy", 32'(busy), 32'(pe.bz));
        chk("sweep_done", 32'(sweep_done), 32'(pe.dn));
      end
    end
  end

  // Monitor for the 2x6 instance
  g_t ge6; p_t pe6;
  always @(negedge clk) begin
    while (gq6.size() > 0 && gq6[0].cyc < cyc) begin
      ge6 = gq6.pop_front();
      chk("gnt6_missed", 32'(cyc), 32'(ge6.cyc));
    end
    while (pq6.size() > 0 && pq6[0].cyc < cyc) begin
      pe6 = pq6.pop_front();
      chk("pulse6_missed", 32'(cyc), 32'(pe6.cyc));
    end
    if (req_gnt6 != '0) begin
      if (gq6.size() == 0) chk("gnt6_unexpected", 32'(req_gnt6), 32'(0));
      else begin
        ge6 = gq6.pop_front();
        chk("gnt6_cyc", 32'(cyc), 32'(ge6.cyc));
        chk("gnt6", 32'(req_gnt6), 32'(ge6.gnt));
      end
    end
    if ((s_drv6 | r_drv6) != '0 || sweep_done6) begin
      if (pq6.size() == 0) chk("pulse6_unexpected", 32'({s_drv6, r_drv6, sweep_done6}), 32'(0));
      else begin
        pe6 = pq6.pop_front();
        chk("pulse6_cyc", 32'(cyc), 32'(pe6.cyc));
        chk("s_drv6", 32'(s_drv6), 32'(pe6.s));
        chk("r_drv6", 32'(r_drv6), 32'(pe6.r));
        chk("flags6", 32'(flags6), 32'(pe6.fl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] fl_tab [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};
  int t0;

  initial begin
    rst = 1'b1; clr_all = 1'b0;
    req_valid = 4'hF; req_op = 4'hF;
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    req_valid6 = '0; req_op6 = '0; req_idx6 = '0;

    // Reset held with every requester valid
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_gnt", 32'(req_gnt), 32'(0));
      chk("rst_flags", 32'(flags), 32'(0));
      chk("rst_sr", 32'({s_drv, r_drv}), 32'(0));
      chk("rst_busy", 32'({busy, sweep_done}), 32'(0));
    end
    tick();
    rst = 1'b0;

    // Fairness: all four held valid, requester i sets flag i
    for (int j = 0; j < 5; j++) begin
      exp_g(1'b0, cyc, 8'(1 << (j % 4)));
      exp_p(1'b0, cyc + 1, 8'(1 << (j % 4)), 8'h00, fl_tab[j], 1'b0, 1'b0);
      tick();
    end
    req_valid = 4'h0;

    // Set then clear flag 5 (pointer now at 1)
    req_valid = 4'b0100; req_op[2] = 1'b1; req_idx[8:6] = 3'd5;
    exp_g(1'b0, cyc, 8'h04);
    exp_p(1'b0, cyc + 1, 8'h20, 8'h00, 8'h2F, 1'b0, 1'b0);
    tick();
    req_valid = 4'b0010; req_op[1] = 1'b0; req_idx[5:3] = 3'd5;
    exp_g(1'b0, cyc, 8'h02);
    exp_p(1'b0, cyc + 1, 8'h00, 8'h20, 8'h0F, 1'b0, 1'b0);
    tick();

    // Fill remaining flags from requester 3
    req_valid = 4'b1000; req_op[3] = 1'b1;
    for (int k = 4; k < 8; k++) begin
      req_idx[11:9] = 3'(k);
      exp_g(1'b0, cyc, 8'h08);
      exp_p(1'b0, cyc + 1, 8'(1 << k), 8'h00, 8'hFF >> (7 - k), 1'b0, 1'b0);
      tick();
    end
    req_valid = 4'h0;

    // Sweep with requester 0 waiting
    t0 = cyc;
    clr_all = 1'b1; req_valid = 4'b0001;
    for (int k = 0; k < 8; k++)
      exp_p(1'b0, t0 + 2 + k, 8'h00, 8'(1 << k), 8'(8'hFF << (k + 1)), (k < 7), 1'b0);
    exp_p(1'b0, t0 + 10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exp_g(1'b0, t0 + 10, 8'h01);
    exp_p(1'b0, t0 + 11, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0);
    tick();
    clr_all = 1'b0;
    @(negedge clk);
    chk("busy_first", 32'(busy), 32'(1));
    repeat (10) tick();
    req_valid = 4'b0010; req_op[1] = 1'b1; req_idx[5:3] = 3'd7;
    exp_g(1'b0, cyc, 8'h02);
    exp_p(1'b0, cyc + 1, 8'h80, 8'h00, 8'h81, 1'b0, 1'b0);
    tick();
    req_valid = 4'h0;

    // Reset in the fourth sweep cycle
    t0 = cyc;
    clr_all = 1'b1;
    exp_p(1'b0, t0 + 2, 8'h00, 8'h01, 8'h80, 1'b1, 1'b0);
    exp_p(1'b0, t0 + 3, 8'h00, 8'h02, 8'h80, 1'b1, 1'b0);
    exp_p(1'b0, t0 + 4, 8'h00, 8'h04, 8'h80, 1'b1, 1'b0);
    tick();
    clr_all = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_flags", 32'(flags), 32'(0));
    chk("midrst_r", 32'(r_drv), 32'(0));
    chk("midrst_done", 32'(sweep_done), 32'(0));
    repeat (12) tick();

    // Six-flag instance: in-range set, then out-of-range set and clear
    req_valid6 = 2'b01; req_op6[0] = 1'b1; req_idx6[2:0] = 3'd2;
    exp_g(1'b1, cyc, 8'h01);
    exp_p(1'b1, cyc + 1, 8'h04, 8'h00, 8'h04, 1'b0, 1'b0);
    tick();
    req_valid6 = 2'b10; req_op6[1] = 1'b1; req_idx6[5:3] = 3'd7;
    exp_g(1'b1, cyc, 8'h02);
    tick();
    req_op6[1] = 1'b0; req_idx6[5:3] = 3'd6;
    exp_g(1'b1, cyc, 8'h02);
    tick();
    req_valid6 = 2'b00;
    @(negedge clk);
    chk("oor_flags6", 32'(flags6), 32'(8'h04));
    chk("oor_sr6", 32'({s_drv6, r_drv6}), 32'(0));

    repeat (3) tick();
    chk("gq_empty", 32'(gq.size()), 32'(0));
    chk("pq_empty", 32'(pq.size()), 32'(0));
    chk("gq6_empty", 32'(gq6.size()), 32'(0));
    chk("pq6_empty", 32'(pq6.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_flag_sched.md
# sr_flag_sched

Round-robin scheduler that shares a bank of `N_FLAG` set/reset status flags between `N_REQ` requesters. It accepts at most one set or clear command per cycle and maintains the flag state. It drives one-cycle `s`/`r` pulses for external SR flip-flop instances and guarantees that `s` and `r` are never asserted together for any bit. It also runs a clear-all sweep that resets the flags one per cycle. The block sits between the requesting FSMs and the SR flag register bank.

## Interface

- `N_REQ`, 4: number of requesters (2..8).
- `N_FLAG`, 8: number of flags (2..16).
- `FW`, `$clog2(N_FLAG)`: flag index width.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  request pending, one bit per requester.
- `req_op`  in  N_REQ  per requester: 1 = set, 0 = clear.
- `req_idx`  in  N_REQ*FW  per-requester target flag index; requester i uses bits [i*FW +: FW].
- `req_gnt`  out  N_REQ  one-hot acceptance strobe (combinational).
- `clr_all`  in  1  start clear-all sweep.
- `flags`  out  N_FLAG  current flag state (registered).
- `s_drv`  out  N_FLAG  registered one-cycle set pulses.
- `r_drv`  out  N_FLAG  registered one-cycle clear pulses.
- `busy`  out  1  high while a sweep is in progress.
- `sweep_done`  out  1  one-cycle pulse after the last flag is cleared.

## Operation

- **Reset values:** `flags`=0, `s_drv`=0, `r_drv`=0, `busy`=0, `sweep_done`=0, RR pointer=0, state=IDLE, sweep count=0. `req_gnt`=0 while `rst` is high.
- **FSM states:** IDLE, SWEEP.
- **IDLE, `clr_all`=1:**
  - Go to SWEEP and set the count to 0.
  - No grant is issued in that cycle; `clr_all` has priority over requests.
- **IDLE, `clr_all`=0, any `req_valid`:**
  - Grant the first valid requester found searching from the pointer upward, wrapping modulo `N_REQ`.
  - The pointer becomes (granted index + 1) mod `N_REQ`. With no grant, the pointer holds.
- **Granted set:** next cycle `flags[idx]`=1 and `s_drv` is one-hot at `idx`.
- **Granted clear:** next cycle `flags[idx]`=0 and `r_drv` is one-hot at `idx`.
- **Redundant commands:** a command is still granted and still pulses even if the flag already holds the target value.
- **Out-of-range index** (`idx` ≥ `N_FLAG`): the command is granted and discarded. No pulse is issued and flags are unchanged.
- **Requester handshake:** the requester holds `valid`, `op` and `idx` stable until it sees `gnt`. It may drop `valid` or issue a new command in the cycle after `gnt`.
- **SWEEP:**
  - Each cycle, `r_drv` is one-hot at the count and `flags[count]`<=0; the count then increments.
  - When the count reaches `N_FLAG`-1, issue the final clear, pulse `sweep_done` in the following cycle, and return to IDLE.
  - `busy`=1 throughout SWEEP.
  - No grants during SWEEP; `clr_all` is ignored. Pending requests wait and are served round-robin afterwards.
- **Invariant:** `s_drv & r_drv` == 0 every cycle; at most one bit of either vector is high.
- **Reset mid-sweep or with grants pending:** next cycle all outputs return to reset values and the sweep is abandoned.

## Timing

- **Grant latency:** `req_gnt` is asserted in the same cycle as a qualifying `req_valid` (combinational from `req_valid` and the pointer).
- **Command latency:** a command granted in cycle T appears on `flags` and `s_drv`/`r_drv` in cycle T+1.
- **Pulse width:** `s_drv`/`r_drv` are high for exactly one cycle per command.
- **Throughput:** one command per cycle in IDLE.
- **Sweep from `clr_all` in cycle T:**
  - `busy`=1 in cycles T+1..T+`N_FLAG`.
  - `r_drv` bit k is high in cycle T+2+k.
  - The FSM is back in IDLE and `sweep_done`=1 in cycle T+`N_FLAG`+2, with `busy`=0 in that cycle.
  - The first post-sweep grant is possible in cycle T+`N_FLAG`+2.
- **Sweep timing at `N_FLAG`=8:** `busy` is high for 8 cycles, followed by `sweep_done`.

## Test plan

- **Reset:** hold `rst` for 2 cycles with all `req_valid`=1 -> `req_gnt`=0, `flags`=0, `s_drv`/`r_drv`=0, `busy`=0.
- **Fairness:** `req_valid`=4'b1111 held, with requester i setting flag i -> grants rotate 0,1,2,3,0; `flags`=8'h0F after 4 grants; exactly one `s_drv` bit per cycle.
- **Set then clear:** requester 2 sets flag 5, then requester 1 clears flag 5 on the next cycle -> `flags[5]`=1 in T+1 and 0 in T+2; `s_drv`=8'h20 then `r_drv`=8'h20; no overlap.
- **Sweep:** `flags`=8'hFF, pulse `clr_all` in cycle T with requester 0 valid -> no grant in T..T+`N_FLAG`; `r_drv` walks 01,02,..,80; `sweep_done` occurs one cycle after `r_drv`=8'h80, i.e. in cycle T+10; `flags`=0; requester 0 is granted when `sweep_done` is high.
- **Reset mid-sweep:** assert `rst` in the 4th sweep cycle -> next cycle `busy`=0, `flags`=0, `r_drv`=0, and no `sweep_done`.
- **Edge cases:** a redundant set on an already-set flag -> granted and `s_drv` pulses; `N_FLAG`=6 with `idx`=7 -> granted, with `flags` and pulses unchanged.
